// File: rtl/vram_pixel_writer_pkg.sv
// Shared definitions for the vram pixel writer.
//   - pixel format encodings carried on the fmt port
//   - FSM state encoding
//   - bpp(): bytes per pixel for a format (2..4)
//   - PIX_W_DEF: default width of the pixel counters
package vram_writer_pkg;

  localparam int PIX_W_DEF = 24;

  localparam logic [1:0] FMT_BGR888   = 2'd0;
  localparam logic [1:0] FMT_RGB565   = 2'd1;
  localparam logic [1:0] FMT_BGRA8888 = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSEMBLE = 2'd1,
    PUSH     = 2'd2,
    DONE     = 2'd3
  } state_e;

  // Encoding 3 is unused by the host and is handled as BGR888.
  function automatic logic [2:0] bpp(input logic [1:0] fmt);
    case (fmt)
      FMT_RGB565:   bpp = 3'd2;
      FMT_BGRA8888: bpp = 3'd4;
      default:      bpp = 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/vram_pixel_writer_rgb_expand.sv
// rgb_expand: combinational conversion of the assembled stream bytes into a
// 24-bit {R,G,B} pixel.
//   i_fmt    in  2      latched frame format
//   i_bytes  in  4x8    stream bytes, index 0 = first byte of the pixel
//   o_rgb    out 24     {r[7:0], g[7:0], b[7:0]}
// RGB565 channels are widened to 8 bits by repeating their MSBs so that
// full-scale 565 values map to 0xFF and zero maps to 0x00.
module rgb_expand
  import vram_writer_pkg::*;
(
  input  logic [1:0]      i_fmt,
  input  logic [3:0][7:0] i_bytes,
  output logic [23:0]     o_rgb
);

  logic [4:0] w_r5;
  logic [5:0] w_g6;
  logic [4:0] w_b5;

  // Little-endian 565 word: b0 = {G[2:0],B[4:0]}, b1 = {R[4:0],G[5:3]}
  assign w_b5 = i_bytes[0][4:0];
  assign w_g6 = {i_bytes[1][2:0], i_bytes[0][7:5]};
  assign w_r5 = i_bytes[1][7:3];

  always_comb begin
    o_rgb = {i_bytes[2], i_bytes[1], i_bytes[0]};
    if (i_fmt == FMT_RGB565)
      o_rgb = {w_r5, w_r5[4:2], w_g6, w_g6[5:4], w_b5, w_b5[4:2]};
    // BGRA8888 shares the BGR888 mapping; byte 3 (alpha) is simply unused.
  end

endmodule

// File: rtl/vram_pixel_writer.sv
// vram_pixel_writer: write side of the video vram FIFO.
// Collects 2/3/4 stream bytes per pixel (by latched fmt), expands them to
// 24-bit RGB and pushes each pixel to the vga block when vram_ready allows.
// Counts pixels per frame and pulses frame_done after the last one.
// Ports:
//   clk_sys, reset            clock, async active-high reset
//   frame_start, frame_pixels arm a frame (IDLE only), pixel count latched
//   fmt                       pixel format, latched on accepted frame_start
//   abort                     flush partial pixel and frame
//   s_data/s_valid/s_ready    byte stream in
//   vram_ready/vram_req       pixel handshake to vga
//   r/g/b_vram_out            pixel to vga, held between requests
//   busy, frame_done          status to control logic
//   px_written                pixels written in current frame
//   err_restart               sticky: frame_start seen while not IDLE
module vram_pixel_writer
  import vram_writer_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [PIX_W-1:0] frame_pixels,
  input  logic [1:0]       fmt,
  input  logic             abort,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             vram_ready,
  output logic             vram_req,
  output logic [7:0]       r_vram_out,
  output logic [7:0]       g_vram_out,
  output logic [7:0]       b_vram_out,
  output logic             busy,
  output logic             frame_done,
  output logic [PIX_W-1:0] px_written,
  output logic             err_restart
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_ASSEMBLE = ASSEMBLE;
  localparam logic [1:0] S_PUSH     = PUSH;
  localparam logic [1:0] S_DONE     = DONE;

  logic [1:0]       r_state;
  logic [1:0]       r_idx;
  logic [1:0]       r_fmt;
  logic [PIX_W-1:0] r_frame_pixels;
  logic [PIX_W-1:0] r_px_written;
  logic [3:0][7:0]  r_bytes;
  logic [23:0]      r_pix;
  logic             r_vram_req;
  logic [23:0]      r_rgb_out;
  logic             r_err_restart;

  logic [3:0][7:0]  w_bytes;
  logic [23:0]      w_rgb;
  logic             w_accept;
  logic             w_last;
  logic [PIX_W-1:0] w_px_inc;

  assign w_accept = (r_state == S_ASSEMBLE) && s_valid;
  assign w_last   = ({1'b0, r_idx} == (bpp(r_fmt) - 3'd1));
  assign w_px_inc = r_px_written + PIX_W'(1);

  // The byte being accepted this cycle is merged in so the final byte of a
  // pixel is expanded and registered on the same edge it is accepted.
  always_comb begin
    w_bytes = r_bytes;
    w_bytes[r_idx] = s_data;
  end

  rgb_expand u_rgb_expand (
    .i_fmt   (r_fmt),
    .i_bytes (w_bytes),
    .o_rgb   (w_rgb)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_idx          <= 2'd0;
      r_fmt          <= 2'd0;
      r_frame_pixels <= '0;
      r_px_written   <= '0;
      r_bytes        <= '0;
      r_pix          <= '0;
      r_vram_req     <= 1'b0;
      r_rgb_out      <= '0;
      r_err_restart  <= 1'b0;
    end else begin
      r_vram_req <= 1'b0;
      if (abort) begin
        r_state       <= S_IDLE;
        r_idx         <= 2'd0;
        r_px_written  <= '0;
        r_err_restart <= 1'b0;
      end else begin
        // A restart request during a frame is only recorded; the frame
        // in flight keeps its latched count and format.
        if (frame_start && (r_state != S_IDLE))
          r_err_restart <= 1'b1;

        case (r_state)
          S_IDLE: begin
            if (frame_start) begin
              r_frame_pixels <= frame_pixels;
              r_fmt          <= fmt;
              r_px_written   <= '0;
              r_idx          <= 2'd0;
              r_state        <= (frame_pixels == '0) ? S_DONE : S_ASSEMBLE;
            end
          end
          S_ASSEMBLE: begin
            if (w_accept) begin
              r_bytes[r_idx] <= s_data;
              if (w_last) begin
                r_pix   <= w_rgb;
                r_idx   <= 2'd0;
                r_state <= S_PUSH;
              end else begin
                r_idx <= r_idx + 2'd1;
              end
            end
          end
          S_PUSH: begin
            if (vram_ready) begin
              r_vram_req   <= 1'b1;
              r_rgb_out    <= r_pix;
              r_px_written <= w_px_inc;
              r_state      <= (w_px_inc == r_frame_pixels) ? S_DONE : S_ASSEMBLE;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign s_ready     = (r_state == S_ASSEMBLE);
  assign busy        = (r_state != S_IDLE);
  assign frame_done  = (r_state == S_DONE);
  assign vram_req    = r_vram_req;
  assign r_vram_out  = r_rgb_out[23:16];
  assign g_vram_out  = r_rgb_out[15:8];
  assign b_vram_out  = r_rgb_out[7:0];
  assign px_written  = r_px_written;
  assign err_restart = r_err_restart;

endmodule
